regfile_wb_sequencer: RTL
=========================

Name: regfile_wb_sequencer

Overview:
- Write-side initiator for the 16x32 register file: queues writeback results from the ALU and load/store paths and turns them into register-file write strobes.
- The register file samples its write address and data on the rising transition of its write or write_pc level, so this block drives address and data one cycle before each strobe.
- It returns the strobe low between consecutive writes.
- It also tells the operand-fetch logic which registers have a pending write (RAW hazard check).

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2, at least 2.
- PTR_W, 2, log2(DEPTH); queue pointer width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result available.
- alu_dest  input  4  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU result accepted this cycle.
- mem_valid  input  1  load result available.
- mem_dest  input  4  load destination register.
- mem_data  input  32  load data.
- mem_ready  output  1  load result accepted this cycle.
- write  output  1  register-file general write strobe.
- dest_add  output  4  register-file write address.
- data_write  output  32  register-file write data.
- write_pc  output  1  register-file PC (r15) write strobe.
- pc_next  output  32  PC write data.
- query_add  input  4  register number being checked by operand fetch.
- query_pending  output  1  a write to query_add is queued or in flight.
- busy  output  1  queue not empty, or the FSM is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Queue emptied and count = 0.
  - FSM goes to IDLE.
  - write, write_pc, dest_add, data_write, pc_next and busy are all 0.
  - A strobe in progress drops to 0 immediately; the partially issued entry is discarded.
- Enqueue:
  - At most one entry is enqueued per cycle.
  - mem has priority: mem_ready = mem_valid && (count < DEPTH).
  - alu_ready = alu_valid && !mem_valid && (count < DEPTH).
  - Both ready outputs are combinational from the registered count.
  - A pop in the same cycle does not free space for an enqueue in that cycle (no full-queue bypass).
  - A source holds valid, dest and data until it sees ready.
- Queue: circular buffer with wrapping rd_ptr and wr_ptr; count is 0..DEPTH.
- FSM (registered outputs):
  - IDLE:
    - write = 0 and write_pc = 0.
    - If count > 0: pop the head into the hold register and go to SETUP.
  - SETUP:
    - write = 0 and write_pc = 0.
    - If hold.dest != 15: dest_add = hold.dest and data_write = hold.data.
    - If hold.dest == 15: pc_next = hold.data and dest_add/data_write are unchanged.
    - Next state: STROBE.
  - STROBE:
    - If hold.dest == 15: write_pc = 1; otherwise write = 1.
    - Address and data are held stable.
    - If count > 0: pop the next entry and go to SETUP (the SETUP cycle also serves as the strobe-low gap).
    - Otherwise go to IDLE.
- Timing:
  - An entry accepted at edge N into an idle block reaches the hold register at edge N+1.
  - Its address/data are on the outputs after edge N+2.
  - Its strobe is high from edge N+3 to edge N+4.
  - Sustained throughput is one register write per 2 cycles.
  - write and write_pc are never high in two consecutive cycles, and never high together.
  - dest_add, data_write and pc_next keep their last values outside SETUP/STROBE.
- Ordering: writes retire in acceptance order; two writes to the same register retire in order, and the later value wins.
- query_pending (combinational): 1 if any valid queue entry, or the hold register while the FSM is in SETUP or STROBE, has dest == query_add. Register r0 gets no special treatment.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Single write: reset, then alu_valid for 1 cycle with dest=3, data=0xDEADBEEF. Required: alu_ready=1 that cycle; dest_add=3 and data_write=0xDEADBEEF one cycle before write; write high exactly 1 cycle, 3 edges after acceptance; write_pc stays 0; busy returns to 0.
- PC write: mem_valid with dest=15, data=0x00000100. Required: pc_next=0x100 before the strobe; write_pc pulses for 1 cycle; write stays 0; dest_add is unchanged.
- Simultaneous sources: alu(dest=1, 0x11) and mem(dest=2, 0x22) both valid in the same cycle and held. Required: mem accepted first with alu_ready=0; alu accepted the next cycle; strobes retire r2 then r1; at least one write-low cycle between the two strobes.
- Backpressure (DEPTH=4): alu_valid held for 8 consecutive results with data 0..7, dests 1..8. Required: ready drops while count is 4; all 8 writes retire in order with correct data; the strobe stays low every other cycle; no entry is lost or duplicated.
- Hazard query: enqueue dest=5 and set query_add=5. Required: query_pending=1 from the cycle after acceptance through the end of the STROBE cycle, then 0. With query_add=6: query_pending stays 0 throughout.
- Reset mid-operation: assert rst_n=0 during a STROBE with 2 entries still queued. Required: write drops to 0 immediately without waiting for clk; after release busy=0, and no further strobes occur without new input.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// Writeback sequencer: queues ALU/load results and issues register-file writes
// as an address/data setup cycle followed by a one-cycle strobe.
module regfile_wb_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [3:0]  alu_dest,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [3:0]  mem_dest,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        write,
   output logic [3:0]  dest_add,
   output logic [31:0] data_write,
   output logic        write_pc,
   output logic [31:0] pc_next,
   input  logic [3:0]  query_add,
   output logic        query_pending,
   output logic        busy
);

   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam logic [REG_W-1:0] PC_REG = REG_W'(15);

   typedef struct packed {
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   state_t            state, state_next;
   wb_entry_t         queue [DEPTH];
   wb_entry_t         hold, hold_next, push_entry;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, offset;
   logic [CNT_W-1:0]  count, count_next;
   logic              push, pop, not_full;
   logic              write_next, write_pc_next, busy_next;
   logic [REG_W-1:0]  dest_add_next;
   logic [DATA_W-1:0] data_write_next, pc_next_next;

   // Load path wins; space is judged on the registered count only (no bypass).
   assign not_full  = count < CNT_W'(DEPTH);
   assign mem_ready = mem_valid && not_full;
   assign alu_ready = alu_valid && !mem_valid && not_full;
   assign push      = mem_ready || alu_ready;

   always_comb begin
      push_entry = '{dest: alu_dest, data: alu_data};
      if (mem_valid) begin
         push_entry = '{dest: mem_dest, data: mem_data};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         queue[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_next;
      end
   end

   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   // State and registered output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold       <= '0;
         write      <= 1'b0;
         write_pc   <= 1'b0;
         dest_add   <= '0;
         data_write <= '0;
         pc_next    <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         hold       <= hold_next;
         write      <= write_next;
         write_pc   <= write_pc_next;
         dest_add   <= dest_add_next;
         data_write <= data_write_next;
         pc_next    <= pc_next_next;
         busy       <= busy_next;
      end
   end

   // Outputs lag the state by one edge: SETUP launches address/data, STROBE the strobe.
   always_comb begin
      state_next      = state;
      hold_next       = hold;
      pop             = 1'b0;
      write_next      = 1'b0;
      write_pc_next   = 1'b0;
      dest_add_next   = dest_add;
      data_write_next = data_write;
      pc_next_next    = pc_next;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               hold_next  = queue[rd_ptr];
               state_next = SETUP;
            end
         end
         SETUP: begin
            if (hold.dest != PC_REG) begin
               dest_add_next   = hold.dest;
               data_write_next = hold.data;
            end else begin
               pc_next_next = hold.data;
            end
            state_next = STROBE;
         end
         STROBE: begin
            if (hold.dest == PC_REG) begin
               write_pc_next = 1'b1;
            end else begin
               write_next = 1'b1;
            end
            if (count != '0) begin
               pop        = 1'b1;
               hold_next  = queue[rd_ptr];
               state_next = SETUP;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy_next = (count_next != '0) || (state_next != IDLE);

   // RAW hazard: any live queue slot or the in-flight hold entry targeting query_add.
   always_comb begin
      query_pending = 1'b0;
      offset        = '0;
      if ((state != IDLE) && (hold.dest == query_add)) begin
         query_pending = 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - rd_ptr;
         if ((CNT_W'(offset) < count) && (queue[i].dest == query_add)) begin
            query_pending = 1'b1;
         end
      end
   end

endmodule
